// File: rtl/locator_pkg.sv
// Shared types and default geometry for the target locator slice.
package locator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_COORD_W  = 10;
  localparam int unsigned DEF_COUNT_W  = 19;
  localparam int unsigned DEF_MIN_HITS = 4;

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: cur_x/cur_y is the coordinate of the pixel on the
// inputs this cycle, with load forcing it to (0,0).
module raster_counter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned COORD_W  = 10
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               advance,
  input  logic               load,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               last_pix
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  always_comb begin
    cur_x    = load ? '0 : x_q;
    cur_y    = load ? '0 : y_q;
    last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);
    x_d      = x_q;
    y_d      = y_q;
    if (advance) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
        y_d = cur_y;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/target_locator.sv
// Reduces a per-pixel match stream to one bounding box + hit count per frame,
// published through a valid/ack result register.
module target_locator
  import locator_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned COORD_W  = DEF_COORD_W,
  parameter int unsigned COUNT_W  = DEF_COUNT_W,
  parameter int unsigned MIN_HITS = DEF_MIN_HITS
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic               match,
  output logic               box_valid,
  input  logic               box_ack,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [COUNT_W-1:0] hit_count,
  output logic               found,
  output logic               overrun,
  output state_e             dbg_state
);

  // Handshake: box_valid stays high from publish until the edge where
  // box_valid & box_ack; a publish on that same edge keeps it high.

  localparam logic [COUNT_W-1:0] MIN_HITS_C = COUNT_W'(MIN_HITS);

  state_e             state_q, state_d;
  logic               accept, restart, publish, last_pix;
  logic [COORD_W-1:0] cur_x, cur_y;

  logic [COORD_W-1:0] acc_xmn_q, acc_xmn_d, acc_xmx_q, acc_xmx_d;
  logic [COORD_W-1:0] acc_ymn_q, acc_ymn_d, acc_ymx_q, acc_ymx_d;
  logic [COUNT_W-1:0] acc_cnt_q, acc_cnt_d;

  logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [COORD_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic [COUNT_W-1:0] hit_count_q, hit_count_d;
  logic               found_q, found_d, box_valid_q, box_valid_d;
  logic               overrun_q, overrun_d;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COORD_W  (COORD_W)
  ) u_raster (
    .clk_50   (clk_50),
    .reset    (reset),
    .advance  (accept),
    .load     (restart),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .last_pix (last_pix)
  );

  always_comb begin
    state_d = state_q;
    restart = pix_valid & frame_start;
    accept  = 1'b0;
    case (state_q)
      IDLE:    accept = restart;
      SCAN:    accept = pix_valid;
      default: accept = 1'b0;
    endcase
    publish = accept & last_pix;
    if (accept) state_d = publish ? IDLE : SCAN;

    // A frame_start pixel discards whatever partial frame was in progress.
    if (restart) begin
      acc_xmn_d = '1;
      acc_xmx_d = '0;
      acc_ymn_d = '1;
      acc_ymx_d = '0;
      acc_cnt_d = '0;
    end else begin
      acc_xmn_d = acc_xmn_q;
      acc_xmx_d = acc_xmx_q;
      acc_ymn_d = acc_ymn_q;
      acc_ymx_d = acc_ymx_q;
      acc_cnt_d = acc_cnt_q;
    end
    if (accept && match) begin
      if (cur_x < acc_xmn_d) acc_xmn_d = cur_x;
      if (cur_x > acc_xmx_d) acc_xmx_d = cur_x;
      if (cur_y < acc_ymn_d) acc_ymn_d = cur_y;
      if (cur_y > acc_ymx_d) acc_ymx_d = cur_y;
      if (acc_cnt_d != '1) acc_cnt_d = acc_cnt_d + 1'b1;
    end

    x_min_d     = x_min_q;
    x_max_d     = x_max_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;
    hit_count_d = hit_count_q;
    found_d     = found_q;
    overrun_d   = 1'b0;
    box_valid_d = box_valid_q & ~box_ack;
    if (publish) begin
      // An empty frame reports a zero box rather than the min/max sentinels.
      if (acc_cnt_d == '0) begin
        x_min_d = '0;
        x_max_d = '0;
        y_min_d = '0;
        y_max_d = '0;
      end else begin
        x_min_d = acc_xmn_d;
        x_max_d = acc_xmx_d;
        y_min_d = acc_ymn_d;
        y_max_d = acc_ymx_d;
      end
      hit_count_d = acc_cnt_d;
      found_d     = (acc_cnt_d >= MIN_HITS_C);
      overrun_d   = box_valid_q & ~box_ack;
      box_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_xmn_q   <= '0;
      acc_xmx_q   <= '0;
      acc_ymn_q   <= '0;
      acc_ymx_q   <= '0;
      acc_cnt_q   <= '0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
      hit_count_q <= '0;
      found_q     <= 1'b0;
      box_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_xmn_q   <= acc_xmn_d;
      acc_xmx_q   <= acc_xmx_d;
      acc_ymn_q   <= acc_ymn_d;
      acc_ymx_q   <= acc_ymx_d;
      acc_cnt_q   <= acc_cnt_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
      hit_count_q <= hit_count_d;
      found_q     <= found_d;
      box_valid_q <= box_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign box_valid = box_valid_q;
  assign x_min     = x_min_q;
  assign x_max     = x_max_q;
  assign y_min     = y_min_q;
  assign y_max     = y_max_q;
  assign hit_count = hit_count_q;
  assign found     = found_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: doc/target_locator.md
# target_locator

Consumes the per-pixel match stream produced by the colour/corner detector and reduces each video frame to a bounding box and hit count of matching pixels. Tracks raster position internally from a pixel-valid strobe and a start-of-frame marker. Publishes one result per completed frame through a valid/ack handshake to the downstream tracking/control logic. Runs in the clk_50 domain alongside the detector.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- COORD_W, 10, coordinate width; must hold max(H_ACTIVE, V_ACTIVE)-1
- COUNT_W, 19, hit counter width; must hold H_ACTIVE*V_ACTIVE
- MIN_HITS, 4, minimum hit count for `found`

Ports:
- clk_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- pix_valid  in  1  one pixel presented this cycle
- frame_start  in  1  qualifies the current pixel as pixel (0,0); ignored unless pix_valid=1
- match  in  1  detector output for the current pixel; ignored unless pix_valid=1
- box_valid  out  1  result registers hold an unacknowledged result
- box_ack  in  1  consumer accepts result
- x_min, x_max  out  COORD_W  bounding box columns
- y_min, y_max  out  COORD_W  bounding box rows
- hit_count  out  COUNT_W  matching pixels in frame
- found  out  1  hit_count >= MIN_HITS
- overrun  out  1  one-cycle pulse: unacknowledged result overwritten

## Operation
- States: IDLE, SCAN. Reset -> IDLE.
- IDLE: pixels ignored until pix_valid&frame_start; that pixel is accepted as (0,0) and state -> SCAN.
- On accepting (0,0): accumulators initialise (min = all ones, max = 0, count = 0), then the pixel is folded in.
- SCAN: each pix_valid pixel is accepted at (x,y); x increments, wrapping to 0 at H_ACTIVE-1 with y increment.
- Accepted pixel with match=1: count+1 (saturating at all ones); x_min/x_max/y_min/y_max updated by compare against current coordinates.
- frame_start with pix_valid during SCAN (not at (0,0) expected position): partial frame discarded, no result, accumulators reinitialise with this pixel as (0,0).
- Final pixel (x=H_ACTIVE-1, y=V_ACTIVE-1) accepted: result published, state -> IDLE.
- Publish: box outputs <= accumulators including final pixel; if count=0, all four box outputs = 0; found = count>=MIN_HITS; box_valid <= 1.
- box_valid clears on edge where box_valid&box_ack, unless a publish occurs on the same edge (publish wins, box_valid stays 1).
- Publish while box_valid=1 and not acked this edge: outputs overwritten, overrun=1 for that one cycle.
- box_ack while box_valid=0: no effect.

## Timing
- Reset values: box_valid=0, overrun=0, found=0, x_min=x_max=y_min=y_max=0, hit_count=0; state IDLE; coordinates 0.
- Latency: outputs and box_valid update on the same edge that samples the final pixel (visible next cycle).
- Output registers stable while box_valid=1 except on overwrite.
- pix_valid gaps of any length permitted; coordinates hold.
- reset mid-frame: partial result lost, outputs to reset values next cycle, pending box_valid dropped.
- Throughput: one pixel per clk_50 cycle; back-to-back frames with zero gap supported (final pixel of frame N then frame_start next cycle).

## Structure
- Package locator_pkg: state enum (IDLE, SCAN), default H_ACTIVE/V_ACTIVE/COORD_W/COUNT_W constants.
- Sub-module raster_counter: x/y counters with pix_valid enable, frame_start load, last-pixel flag output.
- Top holds FSM, bbox/count accumulators, result registers, handshake.

## Test plan
Bench params H_ACTIVE=8, V_ACTIVE=4, MIN_HITS=2.
- Reset, frame with match at (2,1),(5,3),(3,2) -> box_valid=1 one cycle after last pixel, x_min=2, x_max=5, y_min=1, y_max=3, hit_count=3, found=1.
- Frame with no matches -> box 0/0/0/0, hit_count=0, found=0, box_valid=1; ack -> box_valid=0 next cycle.
- Frame with single match (7,0), random pix_valid gaps -> box 7/7/0/0, hit_count=1, found=0.
- Two back-to-back frames, no ack -> second publish overwrites, overrun pulses 1 cycle; ack on same edge as publish -> box_valid stays 1, no overrun.
- frame_start reasserted at pixel 10 of frame -> no result from partial frame; result reflects only restarted frame.
- reset asserted mid-SCAN with box_valid=1 -> all outputs 0 next cycle; pixels ignored until next frame_start.
